// File: rtl/cheri_dmem_pkg.sv
// Shared types and helpers for the CHERIoT data-memory responder.
package cheri_dmem_pkg;

  localparam int unsigned TagBit = 32;
  localparam int unsigned DataW  = 33;

  localparam logic [7:0] LfsrSeed = 8'hA5;
  // Fibonacci taps at bits 7,5,4,3
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  typedef struct packed {
    logic             valid;
    logic             is_read;
    logic             err;
    logic [DataW-1:0] rdata;
  } resp_stage_t;

  // 33-bit offset so that addresses below base wrap high and miss
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned aw);
    logic [32:0] off;
    logic [32:0] size;
    off  = {1'b0, addr} - {1'b0, base};
    size = 33'd4 << aw;
    return off < size;
  endfunction

endpackage

// File: rtl/cheri_dmem_resp_pipe.sv
// Fixed-latency in-order response shift register; SRAM read data joins at stage 1.
module cheri_dmem_resp_pipe
  import cheri_dmem_pkg::*;
#(
  parameter int unsigned RespLatency = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic             push_is_read,
  input  logic             push_err,
  input  logic [DataW-1:0] sram_rdata,
  output logic             head_valid,
  output logic             head_err,
  output logic [DataW-1:0] head_rdata
);

  resp_stage_t stage0_d, stage0_q, cap_c, head_c;

  always_comb begin
    stage0_d         = '0;
    stage0_d.valid   = push_valid;
    stage0_d.is_read = push_is_read;
    stage0_d.err     = push_err;
  end

  always_ff @(posedge clk) begin
    if (rst) stage0_q <= '0;
    else     stage0_q <= stage0_d;
  end

  // SRAM data is valid exactly one cycle after the strobe, i.e. alongside stage 0
  always_comb begin
    cap_c = stage0_q;
    if (stage0_q.valid && stage0_q.is_read) cap_c.rdata = sram_rdata;
  end

  if (RespLatency > 1) begin : g_tail
    localparam int TailN = int'(RespLatency) - 1;
    resp_stage_t tail_q [TailN];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < TailN; i++) tail_q[i] <= '0;
      end else begin
        tail_q[0] <= cap_c;
        for (int i = 1; i < TailN; i++) tail_q[i] <= tail_q[i-1];
      end
    end

    assign head_c = tail_q[TailN-1];
  end else begin : g_direct
    assign head_c = cap_c;
  end

  assign head_valid = head_c.valid;
  assign head_err   = head_c.err;
  assign head_rdata = head_c.is_read ? head_c.rdata : '0;

endmodule

// File: rtl/cheri_dmem_responder.sv
// CHERIoT data-bus responder: decode, grant/outstanding control, tag-clear on partial writes.
// Optional CHERI_DMEM_STALL_EN adds stall_en_i and an LFSR that randomly withholds grants.
module cheri_dmem_responder
  import cheri_dmem_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h2004_0000,
  parameter int unsigned MemAddrW       = 14,
  parameter int unsigned RespLatency    = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
`ifdef CHERI_DMEM_STALL_EN
  input  logic                stall_en_i,
`endif
  input  logic                data_req_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  input  logic                data_we_i,
  input  logic [3:0]          data_be_i,
  input  logic [31:0]         data_addr_i,
  input  logic [DataW-1:0]    data_wdata_i,
  output logic [DataW-1:0]    data_rdata_o,
  output logic                data_err_o,
  output logic                sram_cs_o,
  output logic                sram_we_o,
  output logic [4:0]          sram_be_o,
  output logic [MemAddrW-1:0] sram_addr_o,
  output logic [DataW-1:0]    sram_wdata_o,
  input  logic [DataW-1:0]    sram_rdata_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0]     outst_cnt;
  logic                retire, stall, in_range, hit, keep_tag;
  logic [MemAddrW-1:0] word;
  logic                head_valid, head_err;
  logic [DataW-1:0]    head_rdata;

`ifdef CHERI_DMEM_STALL_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= LfsrSeed;
    else       lfsr <= {lfsr[6:0], ^(lfsr & LfsrTaps)};
  end

  assign stall = stall_en_i & (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign in_range = in_window(data_addr_i, MemBase, MemAddrW);
  assign word     = MemAddrW'((data_addr_i - MemBase) >> 2);
  assign retire   = data_rvalid_o;

  assign data_gnt_o = data_req_i & ~rst_i & ~stall &
                      ((outst_cnt < CntW'(MaxOutstanding)) | retire);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst_cnt <= '0;
    end else if (data_gnt_o && !retire) begin
      outst_cnt <= outst_cnt + CntW'(1);
    end else if (retire && !data_gnt_o) begin
      outst_cnt <= outst_cnt - CntW'(1);
    end
  end

  // Any write narrower than a full word invalidates the capability tag
  assign hit      = data_gnt_o & in_range;
  assign keep_tag = (data_be_i == 4'hF) & data_wdata_i[TagBit];

  assign sram_cs_o    = hit;
  assign sram_we_o    = hit & data_we_i;
  assign sram_addr_o  = hit ? word : '0;
  assign sram_be_o    = hit ? {1'b1, (data_we_i ? data_be_i : 4'hF)} : 5'h00;
  assign sram_wdata_o = (hit & data_we_i) ? {keep_tag, data_wdata_i[31:0]} : '0;

  cheri_dmem_resp_pipe #(
    .RespLatency (RespLatency)
  ) u_resp_pipe (
    .clk          (clk_i),
    .rst          (rst_i),
    .push_valid   (data_gnt_o),
    .push_is_read (~data_we_i & in_range),
    .push_err     (~in_range),
    .sram_rdata   (sram_rdata_i),
    .head_valid   (head_valid),
    .head_err     (head_err),
    .head_rdata   (head_rdata)
  );

  // Responses granted before a reset are suppressed even while reset is high
  assign data_rvalid_o = head_valid & ~rst_i;
  assign data_err_o    = data_rvalid_o & head_err;
  assign data_rdata_o  = data_rvalid_o ? head_rdata : '0;

endmodule

// File: tb/tb_cheri_dmem_responder.sv
// Self-checking bench for cheri_dmem_responder with a queue/array reference model.
module tb_cheri_dmem_responder;

  localparam logic [31:0] Base = 32'h2004_0000;
  localparam int unsigned AW   = 14;
  localparam int unsigned Lat  = 2;
  localparam int unsigned MaxO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, gnt, rvalid, we, err;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [32:0] wdata, rdata;
  logic        cs, swe;
  logic [4:0]  sbe;
  logic [AW-1:0] saddr;
  logic [32:0] swdata, srdata;
  logic        stall_en;

  logic        req1, gnt1, rvalid1, err1, cs1, swe1;
  logic [31:0] addr1;
  logic [32:0] rdata1, swdata1, srdata1;
  logic [4:0]  sbe1;
  logic [AW-1:0] saddr1;

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  typedef struct {
    longint      due;
    logic [32:0] rdata;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  logic [32:0] refm [int];
  logic [32:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cheri_dmem_responder #(.MemBase(Base), .MemAddrW(AW), .RespLatency(Lat), .MaxOutstanding(MaxO)) dut (
    .clk_i(clk), .rst_i(rst),
`ifdef CHERI_DMEM_STALL_EN
    .stall_en_i(stall_en),
`endif
    .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_rdata_o(rdata),
    .data_err_o(err), .sram_cs_o(cs), .sram_we_o(swe), .sram_be_o(sbe),
    .sram_addr_o(saddr), .sram_wdata_o(swdata), .sram_rdata_i(srdata)
  );

  cheri_dmem_responder #(.MemBase(Base), .MemAddrW(AW), .RespLatency(2), .MaxOutstanding(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
`ifdef CHERI_DMEM_STALL_EN
    .stall_en_i(1'b0),
`endif
    .data_req_i(req1), .data_gnt_o(gnt1), .data_rvalid_o(rvalid1), .data_we_i(1'b0),
    .data_be_i(4'hF), .data_addr_i(addr1), .data_wdata_i(33'd0), .data_rdata_o(rdata1),
    .data_err_o(err1), .sram_cs_o(cs1), .sram_we_o(swe1), .sram_be_o(sbe1),
    .sram_addr_o(saddr1), .sram_wdata_o(swdata1), .sram_rdata_i(srdata1)
  );

  // SRAM macro model: byte/tag lane writes, 1-cycle read latency
  logic [32:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (cs) begin
      if (swe) begin
        for (int i = 0; i < 4; i++) if (sbe[i]) sram[saddr][8*i +: 8] <= swdata[8*i +: 8];
        if (sbe[4]) sram[saddr][32] <= swdata[32];
      end else begin
        srdata <= sram[saddr];
      end
    end
  end

  // Second instance only reads; its memory content is a function of the word address
  always @(posedge clk) if (cs1 && !swe1) srdata1 <= {1'b1, 32'hC000_0000 | 32'(saddr1)};

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, Base});
    return (off >= 0) && (off < (longint'(4) << AW));
  endfunction

`ifdef CHERI_DMEM_STALL_EN
  logic [7:0] mlfsr;
  always @(posedge clk) begin
    if (rst) mlfsr <= 8'hA5;
    else     mlfsr <= {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
  end
  wire stall_pred = stall_en && (mlfsr[1:0] == 2'b00);
`else
  wire stall_pred = 1'b0;
`endif

  int          mon_outst;
  int          mon_w;
  exp_t        mon_e;
  logic [32:0] mon_old;

  // Scoreboard: predicts grants, SRAM strobes and in-order responses
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      check("rst_rvalid", 33'(rvalid), 33'd0);
      check("rst_gnt", 33'(gnt), 33'd0);
      check("rst_cs", 33'(cs), 33'd0);
    end else begin
      mon_outst = expq.size();
      check("outst_cnt", 33'(dut.outst_cnt), 33'(mon_outst));
      check("outst_bound", 33'(dut.outst_cnt <= MaxO), 33'd1);
      if (rvalid) begin
        if (expq.size() == 0) begin
          check("spurious_rvalid", 33'(rvalid), 33'd0);
        end else begin
          mon_e = expq.pop_front();
          check("rvalid_cycle", 33'(cyc), 33'(mon_e.due));
          check("rdata", rdata, mon_e.rdata);
          check("err", 33'(err), 33'(mon_e.err));
        end
        last_rdata = rdata;
        last_err   = err;
      end else begin
        check("idle_rdata", rdata, 33'd0);
        check("idle_err", 33'(err), 33'd0);
      end
      check("gnt", 33'(gnt), 33'(req && !stall_pred && (mon_outst < int'(MaxO) || rvalid)));
      check("sram_cs", 33'(cs), 33'(gnt && model_in_range(addr)));
      if (gnt) begin
        mon_e.due = cyc + Lat;
        if (!model_in_range(addr)) begin
          mon_e.err = 1'b1;
          mon_e.rdata = '0;
        end else begin
          mon_w = int'((addr - Base) / 4);
          mon_old = refm.exists(mon_w) ? refm[mon_w] : 33'd0;
          mon_e.err = 1'b0;
          check("sram_addr", 33'(saddr), 33'(mon_w));
          check("sram_we", 33'(swe), 33'(we));
          if (we) begin
            for (int i = 0; i < 4; i++) if (be[i]) mon_old[8*i +: 8] = wdata[8*i +: 8];
            mon_old[32] = (be == 4'hF) ? wdata[32] : 1'b0;
            refm[mon_w] = mon_old;
            mon_e.rdata = '0;
            check("sram_be_w", 33'(sbe), 33'({1'b1, be}));
            check("sram_wdata", swdata, {(be == 4'hF) ? wdata[32] : 1'b0, wdata[31:0]});
          end else begin
            mon_e.rdata = mon_old;
            check("sram_be_r", 33'(sbe), 33'h1F);
          end
        end
        expq.push_back(mon_e);
      end
    end
  end

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [32:0] d);
    bit granted;
    granted = 1'b0;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    for (int k = 0; k < 20 && !granted; k++) begin
      @(negedge clk);
      granted = gnt;
    end
    if (!granted) check("issue_timeout", 33'd0, 33'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
  endtask

  logic [31:0] pool [8];
  int          k1;
  int          lows, pred_lows;

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b0; be = 4'hF; addr = Base; wdata = '0;
    req1 = 1'b0; addr1 = Base; stall_en = 1'b0;
    last_rdata = '0; last_err = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_rdata_o", rdata, 33'd0);
    check("rst_err_o", 33'(err), 33'd0);
    check("rst_sram", {swe, sbe, swdata[26:0]}, 33'd0);
    check("rst_saddr", 33'(saddr), 33'd0);
    req = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Full-word write then read
    issue(1'b1, 4'hF, 32'h2004_0010, {1'b1, 32'hDEAD_BEEF});
    issue(1'b0, 4'hF, 32'h2004_0010, 33'd0);
    idle(4);
    check("wr_rd_data", last_rdata, 33'h1_DEAD_BEEF);
    check("wr_rd_err", 33'(last_err), 33'd0);

    // Partial write clears the tag
    issue(1'b1, 4'hF, 32'h2004_0020, {1'b1, 32'h1111_1111});
    issue(1'b1, 4'b0011, 32'h2004_0020, {1'b1, 32'h0000_ABCD});
    issue(1'b0, 4'hF, 32'h2004_0020, 33'd0);
    idle(4);
    check("partial_tag", last_rdata, 33'h0_1111_ABCD);

    // Zero byte-enable write still clears the tag and succeeds
    issue(1'b1, 4'hF, 32'h2004_0030, {1'b1, 32'h5555_AAAA});
    issue(1'b1, 4'h0, 32'h2004_0030, {1'b1, 32'hFFFF_FFFF});
    idle(4);
    check("be0_err", 33'(last_err), 33'd0);
    issue(1'b0, 4'hF, 32'h2004_0030, 33'd0);
    idle(4);
    check("be0_tag", last_rdata, 33'h0_5555_AAAA);

    // Out-of-range on both sides of the window
    issue(1'b0, 4'hF, 32'h2003_FFFC, 33'd0);
    idle(4);
    check("oor_low_err", 33'(last_err), 33'd1);
    check("oor_low_rdata", last_rdata, 33'd0);
    issue(1'b0, 4'hF, Base + (32'd4 << AW), 33'd0);
    idle(4);
    check("oor_high_err", 33'(last_err), 33'd1);
    check("oor_high_rdata", last_rdata, 33'd0);
    issue(1'b1, 4'hF, Base + (32'd4 << AW) - 32'd4, {1'b1, 32'h0BAD_F00D});
    issue(1'b0, 4'hF, Base + (32'd4 << AW) - 32'd4, 33'd0);
    idle(4);
    check("top_word", last_rdata, 33'h1_0BAD_F00D);

    // MaxOutstanding = 1 instance: grants alternate, responses two cycles later
    k1 = 0;
    for (int i = 0; i < 14; i++) begin
      req1 = (k1 < 6);
      addr1 = Base + 32'(4 * k1);
      @(negedge clk);
      check("b2b_gnt", 33'(gnt1), 33'((i % 2 == 0) && i < 12));
      check("b2b_rvalid", 33'(rvalid1), 33'((i % 2 == 0) && i >= 2));
      if (rvalid1) begin
        check("b2b_rdata", rdata1, {1'b1, 32'hC000_0000 | 32'((i - 2) / 2)});
        check("b2b_err", 33'(err1), 33'd0);
      end
      if (gnt1) k1++;
      @(posedge clk); #1;
    end
    req1 = 1'b0;

    // Reset with two reads in flight
    issue(1'b0, 4'hF, 32'h2004_0010, 33'd0);
    issue(1'b0, 4'hF, 32'h2004_0020, 33'd0);
    do_reset();
    idle(4);
    check("post_rst_cnt", 33'(dut.outst_cnt), 33'd0);
    req = 1'b1; we = 1'b0; addr = 32'h2004_0010;
    @(negedge clk);
    check("post_rst_gnt", 33'(gnt), 33'd1);
    @(posedge clk); #1;
    req = 1'b0;
    idle(4);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 8; i++) begin
      pool[i] = (i == 7) ? Base + (32'd4 << AW) - 32'd4 : Base + 32'h100 + 32'(4 * i);
      issue(1'b1, 4'hF, pool[i], {1'($urandom), 32'($urandom)});
    end
    for (int i = 0; i < 400; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom);
      be    = 4'($urandom);
      addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : pool[$urandom_range(0, 7)];
      wdata = {1'($urandom), 32'($urandom)};
      @(posedge clk); #1;
    end
    req = 1'b0;
    idle(6);
    check("drain", 33'(expq.size()), 33'd0);

`ifdef CHERI_DMEM_STALL_EN
    // LFSR-driven stalls over 256 cycles of continuous requests
    stall_en = 1'b1;
    lows = 0; pred_lows = 0;
    req = 1'b1; we = 1'b0; addr = pool[0];
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!gnt) lows++;
      if (mlfsr[1:0] == 2'b00) pred_lows++;
      @(posedge clk); #1;
      addr = pool[$urandom_range(0, 7)];
    end
    req = 1'b0; stall_en = 1'b0;
    idle(6);
    check("stall_lows", 33'(lows), 33'(pred_lows));
    check("stall_drain", 33'(expq.size()), 33'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
